fir_mac_seq: RTL and testbench
==============================

// Module: fir_mac_seq
// PURPOSE
//  Time-multiplexed FIR dot-product stage fed directly by the 1-D tap shift buffer.
//  On start, snapshots the flattened tap vector and the coefficient vector.
//  Multiply-accumulates one tap per cycle through a single signed multiplier.
//  Emits a rounded, saturated sample with a 1-cycle valid pulse.
// PARAMETERS
//  DataBitWidth   12  signed width of each tap and of y_out
//  BufferSize      5  number of taps (>=2)
//  CoeffBitWidth   8  signed width of each coefficient
//  AccBitWidth    23  accumulator width; must be >= DataBitWidth+CoeffBitWidth+clog2(BufferSize)
//  OutShift        0  arithmetic right shift applied to acc before saturation (0..AccBitWidth-1)
// PORTS
//  clk       in   1                          clock, all logic on posedge
//  rst       in   1                          synchronous, active-high reset
//  start     in   1                          request one dot product; accepted only when ready=1
//  taps_in   in   BufferSize*DataBitWidth    signed taps; tap i = bits [i*DataBitWidth +: DataBitWidth]
//  coeff     in   BufferSize*CoeffBitWidth   signed coeffs; coeff i = bits [i*CoeffBitWidth +: CoeffBitWidth]
//  ready     out  1                          high only in IDLE
//  busy      out  1                          high in MAC and DONE
//  y_out     out  DataBitWidth               signed result; held until next y_valid
//  y_valid   out  1                          1-cycle pulse when y_out/acc_out update
//  acc_out   out  AccBitWidth                full-precision signed sum; held until next y_valid
//  overflow  out  1                          high with y_valid when y_out saturated; else 0
// BEHAVIOUR
//  Reset: state=IDLE, idx=0, acc=0; y_out=0, acc_out=0, y_valid=0, overflow=0, busy=0, ready=1.
//  Reset has priority over every other input in every state; a reset mid-MAC discards the op.
//  States: IDLE, MAC, DONE. ready = (state==IDLE); busy = ~ready.
//  IDLE: if start, latch taps_in and coeff into snapshot regs, set acc=0, set idx=0, go to MAC.
//  MAC: acc <= acc + sext(tap[idx]*coeff[idx]); the product is a full signed DataBitWidth+CoeffBitWidth product.
//  MAC: idx increments each cycle; when idx==BufferSize-1, do the last add and go to DONE.
//  DONE: r = acc + (OutShift>0 ? 1<<(OutShift-1) : 0); s = r >>> OutShift (round half up).
//  DONE: y_out <= sat(s) to [-2^(DataBitWidth-1), 2^(DataBitWidth-1)-1]; acc_out <= acc.
//  DONE: overflow <= (s out of range); y_valid <= 1; go to IDLE.
//  Latency: start sampled at edge t; y_valid is high in the cycle after edge t+BufferSize+1.
//  Throughput: 1 result per BufferSize+2 cycles.
//  start while busy (MAC or DONE) is ignored, not queued; the in-flight result is unaffected.
//  Changes on taps_in/coeff after acceptance do not affect the in-flight result (snapshot).
//  Tap 0 is the oldest sample and tap BufferSize-1 the newest; coeff i always multiplies tap i.
//  The accumulator never wraps given the AccBitWidth rule; there are no intermediate saturations.
//  y_valid and overflow are 0 in every cycle except the DONE-exit pulse.
// TESTING
//  (BufferSize=5, DataBitWidth=12, CoeffBitWidth=8, AccBitWidth=23, OutShift=0 unless noted)
//  1 Ones: all taps=1, all coeffs=1, pulse start -> y_valid exactly 6 cycles later, y_out=5, acc_out=5, overflow=0.
//  2 Impulse: tap4=100, coeff4=-3, others 0 -> y_out=-300, acc_out=-300.
//  3 Saturation: all taps=2047, coeffs=127 -> acc_out=1299845, y_out=2047, overflow=1.
//  3 Saturation: all taps=-2048, coeffs=127 -> acc_out=-1300480, y_out=-2048, overflow=1.
//  4 Busy/snapshot: start, then change taps and re-pulse start during MAC -> result from original taps.
//  4 Busy/snapshot: ready=0 throughout MAC/DONE; exactly one y_valid.
//  5 Reset mid-MAC: assert rst at idx=2 -> next cycle ready=1; all outputs 0; no y_valid follows.
//  6 Rounding, OutShift=2: acc=6 -> y_out=2.
//  6 Rounding, OutShift=2: acc=-6 -> y_out=-1.
//  6 Rounding, OutShift=2: acc=5 -> y_out=1; overflow=0 in all cases.

Source files
------------

// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR dot product: snapshots taps/coeffs on start, runs one
// signed MAC per cycle, then emits a rounded, saturated sample with a valid pulse.
module fir_mac_seq #(
    parameter int DataBitWidth  = 12,
    parameter int BufferSize    = 5,
    parameter int CoeffBitWidth = 8,
    parameter int AccBitWidth   = 23,
    parameter int OutShift      = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [BufferSize*DataBitWidth-1:0]  taps_in,
    input  logic [BufferSize*CoeffBitWidth-1:0] coeff,
    output logic                                ready,
    output logic                                busy,
    output logic [DataBitWidth-1:0]             y_out,
    output logic                                y_valid,
    output logic [AccBitWidth-1:0]              acc_out,
    output logic                                overflow
);

    localparam int ProdW = DataBitWidth + CoeffBitWidth;
    localparam int IdxW  = $clog2(BufferSize);
    localparam int RW    = AccBitWidth + 1;

    localparam logic [IdxW-1:0]     LastIdx = IdxW'(BufferSize - 1);
    localparam logic signed [RW-1:0] RndAdd = RW'((2 ** OutShift) / 2);
    localparam logic signed [RW-1:0] MaxY   = RW'((2 ** (DataBitWidth - 1)) - 1);
    localparam logic signed [RW-1:0] MinY   = ~MaxY;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    state_t state;
    logic [IdxW-1:0] idx;
    logic signed [AccBitWidth-1:0] acc;

    logic signed [DataBitWidth-1:0]  tap_q   [BufferSize];
    logic signed [CoeffBitWidth-1:0] coeff_q [BufferSize];

    logic signed [DataBitWidth-1:0]  cur_tap;
    logic signed [CoeffBitWidth-1:0] cur_coeff;
    logic signed [ProdW-1:0]         prod;
    logic signed [AccBitWidth-1:0]   prod_ext;
    logic signed [RW-1:0]            rnd;
    logic signed [RW-1:0]            shifted;
    logic                            ovf_hi;
    logic                            ovf_lo;
    logic signed [DataBitWidth-1:0]  y_sat;

    assign ready = (state == IDLE);
    assign busy  = ~ready;

    // Snapshot registers carry no reset: they are only read after a fresh capture.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            for (int unsigned i = 0; i < BufferSize; i++) begin
                tap_q[i]   <= taps_in[i*DataBitWidth +: DataBitWidth];
                coeff_q[i] <= coeff[i*CoeffBitWidth +: CoeffBitWidth];
            end
        end
    end

    always_comb begin
        cur_tap   = '0;
        cur_coeff = '0;
        for (int unsigned i = 0; i < BufferSize; i++) begin
            if (idx == IdxW'(i)) begin
                cur_tap   = tap_q[i];
                cur_coeff = coeff_q[i];
            end
        end
    end

    always_comb begin
        prod     = ProdW'(cur_tap) * ProdW'(cur_coeff);
        prod_ext = AccBitWidth'(prod);
        rnd      = RW'(acc) + RndAdd;
        shifted  = rnd >>> OutShift;
        ovf_hi   = (shifted > MaxY);
        ovf_lo   = (shifted < MinY);
        if (ovf_hi) begin
            y_sat = MaxY[DataBitWidth-1:0];
        end else if (ovf_lo) begin
            y_sat = MinY[DataBitWidth-1:0];
        end else begin
            y_sat = shifted[DataBitWidth-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            acc      <= '0;
            y_out    <= '0;
            acc_out  <= '0;
            y_valid  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            y_valid  <= 1'b0;
            overflow <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        idx   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    if (idx == LastIdx) begin
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    y_out    <= y_sat;
                    acc_out  <= acc;
                    overflow <= ovf_hi | ovf_lo;
                    y_valid  <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Bench for fir_mac_seq: two instances (OutShift 0 and 2) share stimulus and are
// compared against a plain-arithmetic dot-product/round/saturate model.
module tb_fir_mac_seq;

    localparam int DW = 12;
    localparam int BS = 5;
    localparam int CW = 8;
    localparam int AW = 23;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [BS*DW-1:0] taps_in;
    logic [BS*CW-1:0] coeff;

    logic ready, busy, y_valid, overflow;
    logic signed [DW-1:0] y_out;
    logic signed [AW-1:0] acc_out;
    logic ready2, busy2, y_valid2, overflow2;
    logic signed [DW-1:0] y_out2;
    logic signed [AW-1:0] acc_out2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_mac_seq #(.DataBitWidth(DW), .BufferSize(BS), .CoeffBitWidth(CW),
                  .AccBitWidth(AW), .OutShift(0)) dut (
        .clk(clk), .rst(rst), .start(start), .taps_in(taps_in), .coeff(coeff),
        .ready(ready), .busy(busy), .y_out(y_out), .y_valid(y_valid),
        .acc_out(acc_out), .overflow(overflow)
    );

    fir_mac_seq #(.DataBitWidth(DW), .BufferSize(BS), .CoeffBitWidth(CW),
                  .AccBitWidth(AW), .OutShift(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .taps_in(taps_in), .coeff(coeff),
        .ready(ready2), .busy(busy2), .y_out(y_out2), .y_valid(y_valid2),
        .acc_out(acc_out2), .overflow(overflow2)
    );

    typedef struct {
        string           name;
        logic [BS*DW-1:0] tp;
        logic [BS*CW-1:0] cf;
        longint          acc;
        longint          y0;
        bit              o0;
        longint          y2;
        bit              o2;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [BS*DW-1:0] pk_t(input int a, input int b, input int c,
                                              input int d, input int e);
        return {DW'(e), DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    function automatic logic [BS*CW-1:0] pk_c(input int a, input int b, input int c,
                                              input int d, input int e);
        return {CW'(e), CW'(d), CW'(c), CW'(b), CW'(a)};
    endfunction

    function automatic vec_t mk(input string n, input logic [BS*DW-1:0] tp,
                                input logic [BS*CW-1:0] cf, input longint a,
                                input longint y0, input bit o0, input longint y2, input bit o2);
        vec_t v;
        v.name = n; v.tp = tp; v.cf = cf; v.acc = a;
        v.y0 = y0; v.o0 = o0; v.y2 = y2; v.o2 = o2;
        return v;
    endfunction

    // Reference: integer dot product, round half up by adding half an LSB, floor shift, clamp.
    function automatic void model(input logic [BS*DW-1:0] tp, input logic [BS*CW-1:0] cf,
                                  input int sh, output longint acc, output longint y,
                                  output bit ovf);
        longint s = 0;
        longint r;
        longint q;
        longint hi = (longint'(1) <<< (DW - 1)) - 1;
        longint lo = -(longint'(1) <<< (DW - 1));
        for (int i = 0; i < BS; i++) begin
            logic signed [DW-1:0] t;
            logic signed [CW-1:0] c;
            t = tp[i*DW +: DW];
            c = cf[i*CW +: CW];
            s += longint'(t) * longint'(c);
        end
        acc = s;
        r = s;
        if (sh > 0) r = s + (longint'(1) <<< (sh - 1));
        q = r >>> sh;
        ovf = (q > hi) || (q < lo);
        y = (q > hi) ? hi : ((q < lo) ? lo : q);
    endfunction

    task automatic check(input string nm, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic do_op(input vec_t v);
        int n;
        bit busy_ok = 1'b1;
        @(negedge clk);
        taps_in = v.tp;
        coeff   = v.cf;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (y_valid === 1'b1) break;
            if (ready !== 1'b0 || busy !== 1'b1) busy_ok = 1'b0;
        end
        check({v.name, ".latency"}, n, 6);
        check({v.name, ".busy_during_op"}, busy_ok, 1);
        check({v.name, ".valid2"}, y_valid2, 1);
        check({v.name, ".ready_after"}, ready, 1);
        check({v.name, ".acc_out"}, acc_out, v.acc);
        check({v.name, ".y_out"}, y_out, v.y0);
        check({v.name, ".overflow"}, overflow, v.o0);
        check({v.name, ".acc_out_sh2"}, acc_out2, v.acc);
        check({v.name, ".y_out_sh2"}, y_out2, v.y2);
        check({v.name, ".overflow_sh2"}, overflow2, v.o2);
        @(posedge clk);
        #1;
        check({v.name, ".pulse_drop"}, {y_valid, overflow, y_valid2, overflow2}, 0);
        check({v.name, ".y_hold"}, y_out, v.y0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_v, second_v, nvalid;
        bit busy_ok;
        vec_t v;

        rst = 1'b1; start = 1'b0; taps_in = '0; coeff = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.ready", ready, 1);
        check("reset.busy", busy, 0);
        check("reset.outs", {y_valid, overflow, y_out, acc_out}, 0);
        check("reset.outs_sh2", {ready2, busy2, y_valid2, overflow2, y_out2, acc_out2},
              {1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 23'd0});
        @(negedge clk) rst = 1'b0;

        vecs.push_back(mk("ones", pk_t(1,1,1,1,1), pk_c(1,1,1,1,1), 5, 5, 0, 1, 0));
        vecs.push_back(mk("impulse", pk_t(0,0,0,0,100), pk_c(0,0,0,0,-3), -300, -300, 0, -75, 0));
        vecs.push_back(mk("sat_pos", pk_t(2047,2047,2047,2047,2047), pk_c(127,127,127,127,127),
                          1299845, 2047, 1, 2047, 1));
        vecs.push_back(mk("sat_neg", pk_t(-2048,-2048,-2048,-2048,-2048), pk_c(127,127,127,127,127),
                          -1300480, -2048, 1, -2048, 1));
        vecs.push_back(mk("rnd_p6", pk_t(6,0,0,0,0), pk_c(1,0,0,0,0), 6, 6, 0, 2, 0));
        vecs.push_back(mk("rnd_m6", pk_t(-6,0,0,0,0), pk_c(1,0,0,0,0), -6, -6, 0, -1, 0));
        vecs.push_back(mk("rnd_p5", pk_t(5,0,0,0,0), pk_c(1,0,0,0,0), 5, 5, 0, 1, 0));
        vecs.push_back(mk("edge_2047", pk_t(2047,0,0,0,0), pk_c(1,0,0,0,0), 2047, 2047, 0, 512, 0));
        vecs.push_back(mk("edge_2048", pk_t(2047,1,0,0,0), pk_c(1,1,0,0,0), 2048, 2047, 1, 512, 0));
        vecs.push_back(mk("edge_m2048", pk_t(-2048,0,0,0,0), pk_c(1,0,0,0,0), -2048, -2048, 0, -512, 0));
        vecs.push_back(mk("edge_m2049", pk_t(-2048,-1,0,0,0), pk_c(1,1,0,0,0), -2049, -2048, 1, -512, 0));
        vecs.push_back(mk("tap_order", pk_t(1,2,3,4,5), pk_c(10,-20,30,-40,50), 150, 150, 0, 38, 0));

        foreach (vecs[k]) do_op(vecs[k]);

        // Start re-pulsed and taps changed while busy: ignored, snapshot preserved.
        @(negedge clk);
        taps_in = pk_t(1,1,1,1,1); coeff = pk_c(1,1,1,1,1); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        nvalid = 0; busy_ok = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 2) begin taps_in = pk_t(100,100,100,100,100); start = 1'b1; end
            if (n == 3) start = 1'b0;
            if (n == 6) start = 1'b1;
            if (n == 7) start = 1'b0;
            @(posedge clk);
            #1;
            if (y_valid === 1'b1) begin
                nvalid++;
                check("snapshot.y_out", y_out, 5);
                check("snapshot.acc_out", acc_out, 5);
            end
            if (n <= 5 && (ready !== 1'b0 || busy !== 1'b1)) busy_ok = 1'b0;
        end
        check("snapshot.valid_count", nvalid, 1);
        check("snapshot.not_ready", busy_ok, 1);

        // Start held high: back-to-back results every BufferSize+2 cycles.
        @(negedge clk);
        taps_in = pk_t(1,1,1,1,1); coeff = pk_c(1,2,3,4,5); start = 1'b1;
        first_v = 0; second_v = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (y_valid === 1'b1) begin
                if (first_v == 0) first_v = n;
                else begin second_v = n; break; end
            end
        end
        @(negedge clk) start = 1'b0;
        check("b2b.first", first_v, 7);
        check("b2b.period", second_v - first_v, 7);
        check("b2b.y_out", y_out, 15);
        repeat (10) @(posedge clk);

        // Reset while idx==2 discards the op.
        @(negedge clk);
        taps_in = pk_t(300,300,300,300,300); coeff = pk_c(9,9,9,9,9); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst.ready", ready, 1);
        check("midrst.busy", busy, 0);
        check("midrst.outs", {y_valid, overflow, y_out, acc_out}, 0);
        @(negedge clk) rst = 1'b0;
        nvalid = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (y_valid === 1'b1 || y_valid2 === 1'b1) nvalid++;
        end
        check("midrst.no_valid", nvalid, 0);

        // Randomized operands, biased toward extremes, against the reference model.
        for (int r = 0; r < 40; r++) begin
            v.name = $sformatf("rand%0d", r);
            for (int i = 0; i < BS; i++) begin
                case ($urandom_range(0, 3))
                    0: v.tp[i*DW +: DW] = ($urandom_range(0, 1) != 0) ? 12'h7FF : 12'h800;
                    default: v.tp[i*DW +: DW] = DW'($urandom);
                endcase
                case ($urandom_range(0, 3))
                    0: v.cf[i*CW +: CW] = ($urandom_range(0, 1) != 0) ? 8'h7F : 8'h80;
                    default: v.cf[i*CW +: CW] = CW'($urandom);
                endcase
            end
            model(v.tp, v.cf, 0, v.acc, v.y0, v.o0);
            model(v.tp, v.cf, 2, v.acc, v.y2, v.o2);
            do_op(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
